membus_arbiter: RTL and testbench
=================================

# membus_arbiter

Parametrised N-master arbiter for the shared video memory bus. It sits between the bus masters (register-bus bridge, one or more layer renderers, a future sprite engine) and the main RAM / character ROM read mux. It grants one request per clock and drives the shared memory address, write and byte-select signals. It returns read data with a registered per-master acknowledge that matches the one-cycle synchronous memory latency. Arbitration is either fixed priority or round-robin, with an optional always-highest-priority CPU port.

## Interface
- NUM_MASTERS, 3: number of requesting masters, 2..8; master 0 is the CPU bridge.
- ADDR_WIDTH, 18: byte address width.
- DATA_WIDTH, 32: memory word width; must be 32.
- RR_MODE, 1: 1 = round-robin among eligible masters; 0 = fixed priority, lowest index wins.
- CPU_PRIO, 1: 1 = master 0 always beats the others regardless of RR_MODE.

Ports:
- clk  in  1  memory clock.
- rst  in  1  reset; asynchronous, active-high.
- m_strobe  in  NUM_MASTERS  per-master request valid.
- m_write  in  NUM_MASTERS  per-master write (1) / read (0).
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master byte address; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_wrdata  in  NUM_MASTERS*8  per-master write byte.
- m_grant  out  NUM_MASTERS  one-hot combinational grant in the request cycle.
- m_ack  out  NUM_MASTERS  one-hot registered acknowledge, one cycle after grant.
- m_rddata  out  DATA_WIDTH  shared read data; valid for whichever m_ack bit is set.
- mem_strobe  out  1  access this cycle.
- mem_write  out  1  write access.
- mem_addr  out  ADDR_WIDTH  granted address; 0 when idle.
- mem_wrdata  out  DATA_WIDTH  granted byte replicated 4 times.
- mem_bytesel  out  4  one-hot lane from mem_addr[1:0]: 00->0001, 01->0010, 10->0100, 11->1000.
- mem_rddata  in  DATA_WIDTH  memory read data, valid one cycle after address.

## Operation
- Each cycle the arbiter picks at most one master from those with m_strobe=1. A master holds strobe, address and data stable until it sees its m_grant bit.
- A grant consumes the request. In the same cycle the master advances; a strobe still high in the next cycle is a new request.
- Winner selection:
  - CPU_PRIO=1 and m_strobe[0]=1: master 0 wins.
  - Otherwise, RR_MODE=0: the lowest index wins.
  - Otherwise, RR_MODE=1: the first requesting index at or after rr_ptr (cyclic) wins. rr_ptr ranges over 1..NUM_MASTERS-1 when CPU_PRIO=1 and over 0..NUM_MASTERS-1 when CPU_PRIO=0.
- rr_ptr updates only on a grant to a non-CPU master (or to any master when CPU_PRIO=0). It becomes winner+1, wrapping from the last index to the lowest round-robin index. A CPU grant leaves rr_ptr unchanged.
- mem_* signals are combinational from the winner. When idle: mem_strobe=0, mem_write=0, mem_addr=0.
- Registered state: ack_q = m_grant (every grant, including writes); m_ack = ack_q.
- m_rddata = mem_rddata passes straight through; it is only meaningful when any m_ack bit is set. Writes also acknowledge; read data is then don't-care.
- No bus idle turnaround: back-to-back grants are allowed every cycle, to the same or different masters.

## Timing
- Reset (asynchronous assert, synchronous release at clk): m_ack=0, ack_q=0, rr_ptr=lowest round-robin index. Combinational outputs follow their inputs.
- Read latency: grant in cycle N; m_ack and m_rddata valid in cycle N+1. The write lands in memory at the clk edge ending cycle N.
- Throughput: 1 access per cycle.
- Worst-case wait for a non-CPU master with CPU_PRIO=1 and RR_MODE=1: (NUM_MASTERS-2) grants plus every CPU cycle. With the CPU idle it is bounded at NUM_MASTERS-2 cycles.
- RR_MODE=0 offers no starvation guarantee.
- Reset asserted in cycle N+1 after a grant in cycle N: m_ack is forced to 0 immediately and that ack is lost. Masters are reset together with the arbiter.
- All strobes low: all grants 0, and rr_ptr is held.

## Test plan
- Single read: NUM_MASTERS=3, master 1 reads addr 0x00105, memory returns 0xAABBCCDD. Required: m_grant=010 and mem_bytesel=0010 in cycle N; m_ack=010 and m_rddata=0xAABBCCDD in N+1.
- CPU priority: masters 0, 1 and 2 all request a write of 0x5A to 0x00003. Required: master 0 granted first, mem_wrdata=0x5A5A5A5A, mem_bytesel=1000; then masters 1 and 2 granted in the next two cycles.
- Round-robin fairness: masters 1 and 2 request continuously for 10 cycles with the CPU idle. Required: grants alternate 1,2,1,2…, exactly 5 each, and m_ack mirrors the grants one cycle later.
- CPU interleave: master 1 and master 2 request continuously while the CPU requests in cycles 2 and 3. Required: cycles 2 and 3 grant master 0; rr order resumes with the master that was next before cycle 2.
- Fixed mode: RR_MODE=0, masters 1 and 2 request continuously for 4 cycles. Required: master 1 is granted every cycle and master 2 is never granted.
- Reset mid-operation: grant master 2 in cycle N, then assert rst in N+1. Required: m_ack=000 immediately; after release, the first round-robin grant with masters 1 and 2 both requesting goes to master 1.

Source files
------------

// File: rtl/membus_arbiter.sv
// Shared video-memory bus arbiter: one grant per clock (fixed priority or round-robin,
// optional CPU override), combinational memory drive and a one-cycle registered acknowledge.
module membus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 32,
    parameter int RR_MODE     = 1,
    parameter int CPU_PRIO    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_strobe,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*8-1:0]          m_wrdata,
    output logic [NUM_MASTERS-1:0]            m_grant,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]             m_rddata,
    output logic                              mem_strobe,
    output logic                              mem_write,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wrdata,
    output logic [3:0]                        mem_bytesel,
    input  logic [DATA_WIDTH-1:0]             mem_rddata
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int RR_LO = (CPU_PRIO != 0) ? 1 : 0;
    localparam int RR_N  = NUM_MASTERS - RR_LO;

    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] ack_q, ack_d;
    logic                   win_valid;
    logic [IDX_W-1:0]       win_idx;
    int                     dist_c, best_c;

    // Round-robin picks the requester at the smallest cyclic distance from rr_ptr.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        dist_c    = 0;
        best_c    = RR_N;
        if (CPU_PRIO != 0 && m_strobe[0]) begin
            win_valid = 1'b1;
        end else if (RR_MODE == 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (m_strobe[i]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int i = RR_LO; i < NUM_MASTERS; i++) begin
                dist_c = i - int'(rr_ptr_q);
                if (dist_c < 0) begin
                    dist_c = dist_c + RR_N;
                end
                if (m_strobe[i] && dist_c < best_c) begin
                    best_c    = dist_c;
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        m_grant    = '0;
        mem_strobe = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wrdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_valid && win_idx == IDX_W'(i)) begin
                m_grant[i] = 1'b1;
                mem_strobe = 1'b1;
                mem_write  = m_write[i];
                mem_addr   = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wrdata = {(DATA_WIDTH/8){m_wrdata[i*8 +: 8]}};
            end
        end
    end

    assign mem_bytesel = 4'b0001 << mem_addr[1:0];

    // CPU grants under CPU_PRIO leave the rotation untouched.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        ack_d    = m_grant;
        if (win_valid && (CPU_PRIO == 0 || win_idx != '0)) begin
            if (int'(win_idx) == NUM_MASTERS - 1) begin
                rr_ptr_d = IDX_W'(RR_LO);
            end else begin
                rr_ptr_d = win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= IDX_W'(RR_LO);
            ack_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
        end
    end

    assign m_ack    = ack_q;
    assign m_rddata = mem_rddata;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: directed literal cases, then randomized traffic compared
// cycle-by-cycle against a queue-based arbitration model and a model memory.
module tb_membus_arbiter;
    localparam int NM = 3;
    localparam int AW = 18;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NM-1:0]    m_strobe = '0;
    logic [NM-1:0]    m_write = '0;
    logic [NM*AW-1:0] m_addr = '0;
    logic [NM*8-1:0]  m_wrdata = '0;
    logic [DW-1:0]    mem_rddata;

    logic [NM-1:0] grant_rr, ack_rr, grant_fx, ack_fx;
    logic [DW-1:0] rd_rr, rd_fx, wrdata_rr, wrdata_fx;
    logic          strobe_rr, write_rr, strobe_fx, write_fx;
    logic [AW-1:0] addr_rr, addr_fx;
    logic [3:0]    bsel_rr, bsel_fx;

    int chk_cnt = 0;
    int pass_cnt = 0;

    membus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1), .CPU_PRIO(1)) dut (
        .clk(clk), .rst(rst), .m_strobe(m_strobe), .m_write(m_write), .m_addr(m_addr),
        .m_wrdata(m_wrdata), .m_grant(grant_rr), .m_ack(ack_rr), .m_rddata(rd_rr),
        .mem_strobe(strobe_rr), .mem_write(write_rr), .mem_addr(addr_rr),
        .mem_wrdata(wrdata_rr), .mem_bytesel(bsel_rr), .mem_rddata(mem_rddata));

    membus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0), .CPU_PRIO(1)) dut_fx (
        .clk(clk), .rst(rst), .m_strobe(m_strobe), .m_write(m_write), .m_addr(m_addr),
        .m_wrdata(m_wrdata), .m_grant(grant_fx), .m_ack(ack_fx), .m_rddata(rd_fx),
        .mem_strobe(strobe_fx), .mem_write(write_fx), .mem_addr(addr_fx),
        .mem_wrdata(wrdata_fx), .mem_bytesel(bsel_fx), .mem_rddata(mem_rddata));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int k);
        return 32'hAABBCCDD + 32'(k - 1) * 32'h01234567;
    endfunction

    // Physical synchronous memory driven by the round-robin instance.
    logic [31:0] phys [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) phys[k] <= init_word(k);
        end else if (strobe_rr && write_rr) begin
            for (int b = 0; b < 4; b++)
                if (bsel_rr[b]) phys[addr_rr[5:2]][b*8 +: 8] <= wrdata_rr[b*8 +: 8];
        end
        mem_rddata <= phys[addr_rr[5:2]];
    end

    // Reference model state.
    logic [31:0]   model_mem [16];
    int            rr_q[$];
    logic [NM-1:0] exp_ack, exp_ack_fx;
    logic          exp_rd_valid;
    logic [31:0]   exp_rd;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_req(int i, logic s, logic w, logic [AW-1:0] a, logic [7:0] d);
        m_strobe[i] = s;
        m_write[i] = w;
        m_addr[i*AW +: AW] = a;
        m_wrdata[i*8 +: 8] = d;
    endtask

    task automatic do_reset();
        m_strobe = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rr_q = {1, 2};
        for (int k = 0; k < 16; k++) model_mem[k] = init_word(k);
        exp_ack = '0;
        exp_ack_fx = '0;
        exp_rd_valid = 1'b0;
        exp_rd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NM-1:0] seq_exp [6];
        logic [NM-1:0] prev_g;
        int n1, n2;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_ack", ack_rr, 0);
        chk("reset_ack_fx", ack_fx, 0);
        chk("reset_grant", grant_rr, 0);
        chk("reset_strobe", strobe_rr, 0);
        chk("reset_addr", addr_rr, 0);

        // Single read by master 1
        do_reset();
        set_req(1, 1'b1, 1'b0, 18'h00105, 8'h00);
        @(negedge clk);
        chk("rd_grant", grant_rr, 3'b010);
        chk("rd_bytesel", bsel_rr, 4'b0010);
        chk("rd_addr", addr_rr, 18'h00105);
        chk("rd_write", write_rr, 0);
        step();
        m_strobe = '0;
        @(negedge clk);
        chk("rd_ack", ack_rr, 3'b010);
        chk("rd_data", rd_rr, 32'hAABBCCDD);
        $display("txn single read m1 addr=00105 data=%08h", rd_rr);

        // CPU priority with three writers
        do_reset();
        for (int i = 0; i < NM; i++) set_req(i, 1'b1, 1'b1, 18'h00003, 8'h5A);
        @(negedge clk);
        chk("cpu_grant0", grant_rr, 3'b001);
        chk("cpu_wrdata", wrdata_rr, 32'h5A5A5A5A);
        chk("cpu_bytesel", bsel_rr, 4'b1000);
        chk("cpu_write", write_rr, 1);
        step();
        m_strobe[0] = 1'b0;
        @(negedge clk);
        chk("cpu_grant1", grant_rr, 3'b010);
        chk("cpu_ack0", ack_rr, 3'b001);
        step();
        m_strobe[1] = 1'b0;
        @(negedge clk);
        chk("cpu_grant2", grant_rr, 3'b100);
        chk("cpu_ack1", ack_rr, 3'b010);
        step();
        m_strobe = '0;
        @(negedge clk);
        chk("cpu_ack2", ack_rr, 3'b100);
        chk("cpu_idle_grant", grant_rr, 0);
        $display("txn cpu-priority writes granted m0,m1,m2");

        // Round-robin fairness, fixed-priority instance sees the same requests
        do_reset();
        set_req(1, 1'b1, 1'b0, 18'h00010, 8'h00);
        set_req(2, 1'b1, 1'b0, 18'h00020, 8'h00);
        n1 = 0;
        n2 = 0;
        prev_g = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rr_grant", grant_rr, (c % 2 == 0) ? 3'b010 : 3'b100);
            chk("rr_ack", ack_rr, prev_g);
            chk("fixed_grant", grant_fx, 3'b010);
            if (grant_rr == 3'b010) n1++;
            if (grant_rr == 3'b100) n2++;
            prev_g = grant_rr;
            $display("txn rr cycle %0d grant=%b fixed=%b", c, grant_rr, grant_fx);
            step();
        end
        chk("rr_count_m1", n1, 5);
        chk("rr_count_m2", n2, 5);

        // CPU interleave
        do_reset();
        set_req(1, 1'b1, 1'b0, 18'h00030, 8'h00);
        set_req(2, 1'b1, 1'b0, 18'h00034, 8'h00);
        set_req(0, 1'b0, 1'b0, 18'h00038, 8'h00);
        seq_exp = '{3'b010, 3'b100, 3'b001, 3'b001, 3'b010, 3'b100};
        for (int c = 0; c < 6; c++) begin
            m_strobe[0] = (c == 2 || c == 3);
            @(negedge clk);
            chk("interleave_grant", grant_rr, seq_exp[c]);
            $display("txn interleave cycle %0d grant=%b", c, grant_rr);
            step();
        end

        // Reset mid-operation after a grant to master 2
        do_reset();
        set_req(2, 1'b1, 1'b0, 18'h00040, 8'h00);
        @(negedge clk);
        chk("rst_pre_grant", grant_rr, 3'b100);
        step();
        m_strobe = '0;
        rst = 1'b1;
        #1;
        chk("rst_ack_lost", ack_rr, 3'b000);
        do_reset();
        set_req(1, 1'b1, 1'b0, 18'h00044, 8'h00);
        set_req(2, 1'b1, 1'b0, 18'h00048, 8'h00);
        @(negedge clk);
        chk("rst_first_rr", grant_rr, 3'b010);
        // After master 1 wins the pointer sits on 2; reset must bring it back to 1.
        step();
        m_strobe = '0;
        rst = 1'b1;
        #1;
        chk("rst_ack_lost2", ack_rr, 3'b000);
        do_reset();
        set_req(1, 1'b1, 1'b0, 18'h00044, 8'h00);
        set_req(2, 1'b1, 1'b0, 18'h00048, 8'h00);
        @(negedge clk);
        chk("rst_ptr_restored", grant_rr, 3'b010);
        $display("txn reset mid-operation done");

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < NM; i++)
            set_req(i, ($urandom_range(0, 99) < (i == 0 ? 20 : 60)), 1'($urandom),
                    AW'($urandom), 8'($urandom));
        for (int cyc = 0; cyc < 800; cyc++) begin
            int w, wf;
            logic [NM-1:0] eg, egf;
            logic [AW-1:0] a;
            logic [7:0] d;
            logic wr;
            @(negedge clk);
            w = -1;
            if (m_strobe[0]) w = 0;
            else foreach (rr_q[k]) if (w < 0 && m_strobe[rr_q[k]]) w = rr_q[k];
            wf = -1;
            for (int i = 0; i < NM; i++) if (wf < 0 && m_strobe[i]) wf = i;
            eg = '0;
            egf = '0;
            if (w >= 0) eg[w] = 1'b1;
            if (wf >= 0) egf[wf] = 1'b1;
            chk("m_grant", grant_rr, eg);
            chk("m_grant_fx", grant_fx, egf);
            chk("m_ack", ack_rr, exp_ack);
            chk("m_ack_fx", ack_fx, exp_ack_fx);
            chk("mem_strobe", strobe_rr, (w >= 0));
            if (exp_rd_valid) chk("m_rddata", rd_rr, exp_rd);
            exp_ack = eg;
            exp_ack_fx = egf;
            exp_rd_valid = 1'b0;
            if (w >= 0) begin
                a = m_addr[w*AW +: AW];
                d = m_wrdata[w*8 +: 8];
                wr = m_write[w];
                chk("mem_addr", addr_rr, a);
                chk("mem_write", write_rr, wr);
                chk("mem_bytesel", bsel_rr, 4'b0001 << a[1:0]);
                if (wr) begin
                    chk("mem_wrdata", wrdata_rr, {4{d}});
                    model_mem[a[5:2]][a[1:0]*8 +: 8] = d;
                end else begin
                    exp_rd_valid = 1'b1;
                    exp_rd = model_mem[a[5:2]];
                end
                if (w != 0) begin
                    int x;
                    do begin
                        x = rr_q.pop_front();
                        rr_q.push_back(x);
                    end while (x != w);
                end
                $display("txn cyc %0d m%0d %s addr=%05h", cyc, w, wr ? "wr" : "rd", a);
            end else begin
                chk("mem_addr_idle", addr_rr, 0);
                chk("mem_write_idle", write_rr, 0);
            end
            step();
            for (int i = 0; i < NM; i++)
                if (i == w || !m_strobe[i])
                    set_req(i, ($urandom_range(0, 99) < (i == 0 ? 20 : 60)), 1'($urandom),
                            AW'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
